// File: rtl/md_cart_rom.sv
// Cartridge ROM read bridge: settles the console address, fetches a word from a
// request/ack backend with timeout, and serves repeats from a one-entry cache.
module md_cart_rom #(
  parameter int unsigned SETTLE_CYCLES  = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [20:0] ADDR_MASK      = 21'h1FFFFF
) (
  input  logic        MCLK,
  input  logic        SRES,
  input  logic [20:0] cart_address,
  input  logic        cart_cs,
  input  logic        cart_oe,
  output logic [15:0] cart_data,
  output logic [20:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW  = 21;
  localparam int unsigned DW  = 16;
  localparam int unsigned SCW = 4;
  localparam int unsigned TCW = 8;

  localparam logic [SCW-1:0] SETTLE_LAST  = SCW'(SETTLE_CYCLES - 1);
  localparam logic [TCW-1:0] TIMEOUT_LAST = TCW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, FETCH, HOLD} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [SCW-1:0]  settle_q, settle_d;
  logic [TCW-1:0]  to_q, to_d;
  logic [DW-1:0]   data_q, data_d;
  logic [AW-1:0]   cache_addr_q, cache_addr_d;
  logic            cache_valid_q, cache_valid_d;
  logic            err_d;
  logic            mem_req_d;
  logic [AW-1:0]   mem_addr_d;
  logic            fetch_done;

  logic            access;
  logic [AW-1:0]   cur_addr;
  logic            hit;

  assign access   = cart_cs & cart_oe;
  assign cur_addr = cart_address & ADDR_MASK;
  assign hit      = cache_valid_q && (cur_addr == cache_addr_q);

  // The console bus is wired-OR, so only HOLD may drive non-zero data.
  assign cart_data = (state_q == HOLD) ? data_q : '0;
  assign busy      = (state_q == SETTLE) || (state_q == FETCH);

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    settle_d      = settle_q;
    to_d          = to_q;
    data_d        = data_q;
    cache_addr_d  = cache_addr_q;
    cache_valid_d = cache_valid_q;
    err_d         = err;
    mem_req_d     = mem_req;
    mem_addr_d    = mem_addr;
    fetch_done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (access) begin
          addr_d = cur_addr;
          if (hit) begin
            state_d = HOLD;
          end else begin
            state_d  = SETTLE;
            settle_d = '0;
          end
        end
      end

      SETTLE: begin
        if (!access) begin
          state_d = IDLE;
        end else if (hit) begin
          state_d = HOLD;
          addr_d  = cur_addr;
        end else if (cur_addr != addr_q) begin
          addr_d   = cur_addr;
          settle_d = '0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d    = FETCH;
          mem_req_d  = 1'b1;
          mem_addr_d = addr_q;
          to_d       = '0;
        end else begin
          settle_d = settle_q + SCW'(1);
        end
      end

      FETCH: begin
        // An ack in the final timeout cycle still wins over the timeout.
        if (mem_ack) begin
          data_d        = mem_rdata;
          cache_addr_d  = mem_addr;
          cache_valid_d = 1'b1;
          fetch_done    = 1'b1;
        end else if (to_q == TIMEOUT_LAST) begin
          data_d        = 16'hFFFF;
          err_d         = 1'b1;
          cache_valid_d = 1'b0;
          fetch_done    = 1'b1;
        end else begin
          to_d = to_q + TCW'(1);
        end

        if (fetch_done) begin
          mem_req_d = 1'b0;
          if (access && (cur_addr == mem_addr)) begin
            state_d = HOLD;
          end else if (access) begin
            state_d  = SETTLE;
            addr_d   = cur_addr;
            settle_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      HOLD: begin
        if (!access) begin
          state_d = IDLE;
        end else if (cur_addr != addr_q) begin
          addr_d = cur_addr;
          if (!hit) begin
            state_d  = SETTLE;
            settle_d = '0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (!SRES) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      settle_q      <= '0;
      to_q          <= '0;
      data_q        <= '0;
      cache_addr_q  <= '0;
      cache_valid_q <= 1'b0;
      err           <= 1'b0;
      mem_req       <= 1'b0;
      mem_addr      <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      settle_q      <= settle_d;
      to_q          <= to_d;
      data_q        <= data_d;
      cache_addr_q  <= cache_addr_d;
      cache_valid_q <= cache_valid_d;
      err           <= err_d;
      mem_req       <= mem_req_d;
      mem_addr      <= mem_addr_d;
    end
  end

endmodule

// File: tb/tb_md_cart_rom.sv
// Bench for md_cart_rom: directed scenarios, then random reads scored against a
// one-entry cache model with per-read expected data, latency and error flag.
module tb_md_cart_rom;

  localparam int unsigned SETTLE = 2;
  localparam int unsigned TO     = 8;
  localparam logic [20:0] MASK   = 21'h07FFFF;

  typedef struct { logic [15:0] d; int lat; logic e; } exp_t;
  typedef struct { int k; logic [15:0] d; } resp_t;

  logic        MCLK, SRES;
  logic [20:0] cart_address;
  logic        cart_cs, cart_oe;
  logic [15:0] cart_data;
  logic [20:0] mem_addr;
  logic        mem_req, mem_ack;
  logic [15:0] mem_rdata;
  logic        busy, err;

  logic        dir_ack, rsp_ack;
  logic [15:0] dir_rdata, rsp_rdata;
  assign mem_ack   = dir_ack | rsp_ack;
  assign mem_rdata = rsp_ack ? rsp_rdata : dir_rdata;

  int   n_vec = 0;
  int   n_bad = 0;
  int   n_done = 0;
  bit   sb_en = 0;
  bit   auto_resp = 0;

  logic [20:0] fetch_q[$];
  exp_t        exp_q[$];
  resp_t       resp_q[$];

  md_cart_rom #(.SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TO), .ADDR_MASK(MASK)) dut (
    .MCLK(MCLK), .SRES(SRES), .cart_address(cart_address), .cart_cs(cart_cs),
    .cart_oe(cart_oe), .cart_data(cart_data), .mem_addr(mem_addr), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .err(err)
  );

  initial MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    SRES = 1'b0; cart_cs = 1'b0; cart_oe = 1'b0; cart_address = '0;
    dir_ack = 1'b0; dir_rdata = '0;
    repeat (3) @(negedge MCLK);
    SRES = 1'b1;
  endtask

  task automatic go(input logic [20:0] a);
    @(negedge MCLK);
    cart_address = a; cart_cs = 1'b1; cart_oe = 1'b1;
  endtask

  task automatic idle();
    @(negedge MCLK);
    cart_cs = 1'b0; cart_oe = 1'b0;
    @(negedge MCLK);
  endtask

  task automatic ack(input logic [15:0] d);
    dir_ack = 1'b1; dir_rdata = d;
    @(negedge MCLK);
    dir_ack = 1'b0;
  endtask

  task automatic wait_req(output bit got);
    int i;
    got = 1'b0;
    i = 0;
    while (!got && i < 30) begin
      @(negedge MCLK);
      got = mem_req;
      i++;
    end
  endtask

  // Backend model for the random phase: acks in cycle k of the request, unless it was withdrawn.
  initial begin : responder
    resp_t r;
    rsp_ack = 1'b0; rsp_rdata = '0;
    forever begin
      @(negedge MCLK);
      if (auto_resp && mem_req && resp_q.size() > 0) begin
        r = resp_q.pop_front();
        for (int j = 1; j < r.k; j++) @(negedge MCLK);
        if (mem_req) begin
          rsp_ack = 1'b1; rsp_rdata = r.d;
          @(negedge MCLK);
          rsp_ack = 1'b0;
        end
      end
    end
  end

  // Monitor: scores each new request address and the first HOLD cycle of every access.
  initial begin : monitor
    logic a_s, req_prev;
    int   lat;
    bit   seen;
    exp_t e;
    req_prev = 1'b0; lat = 0; seen = 1'b0;
    forever begin
      @(posedge MCLK);
      a_s = cart_cs & cart_oe;
      #1;
      if (!sb_en) begin
        req_prev = 1'b0; lat = 0; seen = 1'b0;
      end else begin
        if (mem_req && !req_prev) begin
          if (fetch_q.size() == 0) begin
            n_vec++; n_bad++;
            $display("FAIL fetch_unexpected: got request to %h expected no request", mem_addr);
          end else begin
            chk("fetch_addr", 32'(mem_addr), 32'(fetch_q.pop_front()));
          end
        end
        req_prev = mem_req;
        if (a_s) begin
          lat++;
          if (!busy && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
              n_vec++; n_bad++;
              $display("FAIL hold_unexpected: got data %h expected no read", cart_data);
            end else begin
              e = exp_q.pop_front();
              chk("rd_data", 32'(cart_data), 32'(e.d));
              chk("rd_latency", 32'(lat), 32'(e.lat));
              chk("rd_err", 32'(err), 32'(e.e));
            end
            n_done++;
          end
        end else begin
          lat = 0; seen = 1'b0;
        end
      end
    end
  end

  initial begin : main
    bit          got;
    int          cnt, nreq, start, w;
    logic        prev, m_valid, m_err;
    logic [20:0] ra, a, ma, m_addr;
    logic [15:0] m_data;
    exp_t        e;
    resp_t       r;

    do_reset();
    @(negedge MCLK);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_cart_data", 32'(cart_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err), 0);

    // Miss, then hit on the same address.
    go(21'h000100);
    wait_req(got);
    chk("t1_req", 32'(got), 1);
    chk("t1_addr", 32'(mem_addr), 32'h000100);
    @(negedge MCLK); @(negedge MCLK);
    ack(16'h4E71);
    chk("t1_data", 32'(cart_data), 32'h4E71);
    chk("t1_req_drop", 32'(mem_req), 0);
    chk("t1_busy", 32'(busy), 0);
    ack(16'hDEAD);
    chk("t1_stray_ack", 32'(cart_data), 32'h4E71);
    idle();
    chk("t1_idle_data", 32'(cart_data), 0);
    go(21'h000100);
    @(negedge MCLK);
    chk("t1_hit_data", 32'(cart_data), 32'h4E71);
    chk("t1_hit_noreq", 32'(mem_req), 0);

    // Address glitch while settling.
    idle();
    go(21'h000200);
    @(negedge MCLK);
    cart_address = 21'h000204;
    nreq = 0; prev = 1'b0; ra = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge MCLK);
      dir_ack = 1'b0;
      if (mem_req && !prev) begin
        nreq++; ra = mem_addr;
        dir_ack = 1'b1; dir_rdata = 16'h1234;
      end
      prev = mem_req;
    end
    dir_ack = 1'b0;
    chk("t2_nreq", 32'(nreq), 1);
    chk("t2_addr", 32'(ra), 32'h000204);
    chk("t2_data", 32'(cart_data), 32'h1234);

    // Timeout with no ack, then refetch of the same address.
    idle();
    go(21'h000300);
    wait_req(got);
    chk("t3_req", 32'(got), 1);
    cnt = 0;
    while (mem_req && cnt < 20) begin
      cnt++;
      @(negedge MCLK);
    end
    chk("t3_req_cycles", 32'(cnt), TO);
    chk("t3_data", 32'(cart_data), 32'hFFFF);
    chk("t3_err", 32'(err), 1);
    idle();
    go(21'h000300);
    wait_req(got);
    chk("t3_refetch", 32'(got), 1);
    ack(16'h0BAD);
    chk("t3_data2", 32'(cart_data), 32'h0BAD);
    chk("t3_err_sticky", 32'(err), 1);

    // Access abandoned mid-fetch; late data still fills the cache.
    idle();
    go(21'h000400);
    wait_req(got);
    @(negedge MCLK);
    cart_cs = 1'b0;
    repeat (3) @(negedge MCLK);
    chk("t4_req_held", 32'(mem_req), 1);
    ack(16'hA5A5);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_idle_data", 32'(cart_data), 0);
    go(21'h000400);
    @(negedge MCLK);
    chk("t4_hit_data", 32'(cart_data), 32'hA5A5);
    chk("t4_hit_noreq", 32'(mem_req), 0);

    // Mirrored address hits.
    idle();
    go(21'h000010);
    wait_req(got);
    ack(16'h1111);
    chk("t5_data", 32'(cart_data), 32'h1111);
    idle();
    go(21'h080010);
    @(negedge MCLK);
    chk("t5_mirror_data", 32'(cart_data), 32'h1111);
    chk("t5_mirror_noreq", 32'(mem_req), 0);
    chk("t5_mirror_busy", 32'(busy), 0);

    // Reset during a fetch; the late ack must be ignored.
    idle();
    go(21'h000500);
    wait_req(got);
    chk("t6_req", 32'(got), 1);
    SRES = 1'b0; cart_cs = 1'b0; cart_oe = 1'b0;
    @(negedge MCLK);
    SRES = 1'b1;
    chk("t6_req_drop", 32'(mem_req), 0);
    chk("t6_err_clr", 32'(err), 0);
    chk("t6_mem_addr", 32'(mem_addr), 0);
    ack(16'h7777);
    chk("t6_late_ack_req", 32'(mem_req), 0);
    chk("t6_late_ack_data", 32'(cart_data), 0);
    go(21'h000010);
    @(negedge MCLK);
    chk("t6_cache_cleared", 32'(busy), 1);
    wait_req(got);
    ack(16'h2222);
    idle();

    // Random reads against the cache model.
    do_reset();
    @(negedge MCLK);
    sb_en = 1'b1; auto_resp = 1'b1;
    m_valid = 1'b0; m_err = 1'b0; m_addr = '0; m_data = '0;
    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 3))
        0:       a = 21'h000010;
        1:       a = 21'h080010;
        2:       a = 21'h1F0200;
        default: a = 21'($urandom);
      endcase
      ma = a & MASK;
      if (m_valid && m_addr == ma) begin
        e.d = m_data; e.lat = 1;
      end else begin
        r.k = int'($urandom_range(1, 10));
        r.d = 16'($urandom);
        fetch_q.push_back(ma);
        resp_q.push_back(r);
        if (r.k <= int'(TO)) begin
          m_valid = 1'b1; m_addr = ma; m_data = r.d;
          e.d = r.d; e.lat = int'(SETTLE) + r.k + 1;
        end else begin
          m_valid = 1'b0; m_err = 1'b1;
          e.d = 16'hFFFF; e.lat = int'(SETTLE + TO) + 1;
        end
      end
      e.e = m_err;
      exp_q.push_back(e);
      start = n_done;
      go(a);
      w = 0;
      while (n_done == start && w < 40) begin
        @(negedge MCLK);
        w++;
      end
      chk("txn_done", 32'(n_done - start), 1);
      repeat ($urandom_range(0, 2)) @(negedge MCLK);
      @(negedge MCLK);
      if ($urandom_range(0, 1) == 1) cart_cs = 1'b0;
      else cart_oe = 1'b0;
    end
    repeat (5) @(negedge MCLK);
    sb_en = 1'b0; auto_resp = 1'b0;
    chk("fetch_q_left", 32'(fetch_q.size()), 0);
    chk("exp_q_left", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
